// File: rtl/lc3_int_pkg.sv
// Shared types and constants for the LC-3 interrupt/exception vector controller.
package lc3_int_pkg;

  localparam int PRI_W = 3;
  localparam int VEC_W = 8;

  localparam logic [7:0] TABLE_BASE = 8'h01;

  typedef enum logic [1:0] {
    VEC_INT  = 2'd0,
    VEC_PRIV = 2'd1,
    VEC_ILL  = 2'd2,
    VEC_ACV  = 2'd3
  } vec_mux_e;

  localparam logic [VEC_W-1:0] EXC_PRIV_VEC = 8'h00;
  localparam logic [VEC_W-1:0] EXC_ILL_VEC  = 8'h01;
  localparam logic [VEC_W-1:0] EXC_ACV_VEC  = 8'h02;

endpackage

// File: rtl/lc3_int_src.sv
// One interrupt source: input synchronizer, rising-edge pending flag, level/edge select.
// INT_CTRL_SYNC_EN selects a 2-flop synchronizer instead of a single input register.
module lc3_int_src
  import lc3_int_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic irq_req,
  input  logic clr,
  output logic active
);

  logic synced;

`ifdef INT_CTRL_SYNC_EN
  logic meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= irq_req;
      synced <= meta;
    end
  end
`else
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) synced <= 1'b0;
    else         synced <= irq_req;
  end
`endif

  logic synced_q;
  logic pending;
  logic rise;
  logic pending_nxt;

  assign rise = synced & ~synced_q;
  // A fresh edge arriving on the clearing edge must survive the clear.
  assign pending_nxt = rise | (pending & ~clr);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      synced_q <= 1'b0;
      pending  <= 1'b0;
      active   <= 1'b0;
    end else begin
      synced_q <= synced;
      pending  <= pending_nxt;
      active   <= EDGE ? pending_nxt : synced;
    end
  end

endmodule

// File: rtl/lc3_int_ctrl.sv
// LC-3 interrupt controller: fixed-priority arbitration, vector register, bus gate.
// Optional INT_CTRL_SYNC_EN adds a 2-flop synchronizer per source.
module lc3_int_ctrl
  import lc3_int_pkg::*;
#(
  parameter int                       N_SRC        = 2,
  parameter logic [PRI_W*N_SRC-1:0]   SRC_PRI      = {3'd5, 3'd4},
  parameter logic [VEC_W*N_SRC-1:0]   SRC_VEC      = {8'h81, 8'h80},
  parameter logic [N_SRC-1:0]         EDGE_MASK    = 2'b00,
  parameter logic [VEC_W-1:0]         SPURIOUS_VEC = 8'hFF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [N_SRC-1:0] irq_req,
  output logic [N_SRC-1:0] irq_ack,
  output logic [PRI_W-1:0] int_pri,
  input  logic             int_ld_vec,
  input  logic [2:0]       int_vec_mux,
  input  logic             int_gate_vec,
  inout  wire  [15:0]      bus
);

  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] grant;
  logic [N_SRC-1:0] clr;
  logic [PRI_W-1:0] win_pri;
  logic [VEC_W-1:0] win_vec;
  logic [VEC_W-1:0] vec;
  vec_mux_e         vec_sel;
  logic             unused_mux_bit;

  assign vec_sel        = vec_mux_e'(int_vec_mux[1:0]);
  assign unused_mux_bit = int_vec_mux[2];

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    lc3_int_src #(.EDGE(EDGE_MASK[g])) u_src (
      .clk     (clk),
      .arst_n  (arst_n),
      .irq_req (irq_req[g]),
      .clr     (clr[g]),
      .active  (active[g])
    );
  end

  // Strict '>' while scanning upward gives ties to the lowest index; priority 0 never beats the seed.
  always_comb begin
    win_pri = '0;
    win_vec = SPURIOUS_VEC;
    grant   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (active[i] && (SRC_PRI[PRI_W*i +: PRI_W] > win_pri)) begin
        win_pri  = SRC_PRI[PRI_W*i +: PRI_W];
        win_vec  = SRC_VEC[VEC_W*i +: VEC_W];
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  assign clr = (int_ld_vec && (vec_sel == VEC_INT)) ? grant : '0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      int_pri <= '0;
      irq_ack <= '0;
      vec     <= '0;
    end else begin
      int_pri <= win_pri;
      irq_ack <= clr;
      if (int_ld_vec) begin
        case (vec_sel)
          VEC_INT:  vec <= win_vec;
          VEC_PRIV: vec <= EXC_PRIV_VEC;
          VEC_ILL:  vec <= EXC_ILL_VEC;
          VEC_ACV:  vec <= EXC_ACV_VEC;
          default:  vec <= vec;
        endcase
      end
    end
  end

  // Released during reset even if the gate strobe is stuck high.
  assign bus = (int_gate_vec && arst_n) ? {TABLE_BASE, vec} : 16'hzzzz;

endmodule

// File: tb/tb_lc3_int_ctrl.sv
// Bench for lc3_int_ctrl: directed scenarios plus random traffic against a history-based model.
module tb_lc3_int_ctrl;

  localparam int N = 4;
  localparam logic [3*N-1:0] P_PRI  = {3'd0, 3'd5, 3'd4, 3'd4};
  localparam logic [8*N-1:0] P_VEC  = {8'h83, 8'h82, 8'h81, 8'h80};
  localparam logic [N-1:0]   P_EDGE = 4'b0101;
`ifdef INT_CTRL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic [N-1:0] irq_req = '0;
  logic [N-1:0] irq_ack;
  logic [2:0]   int_pri;
  logic         int_ld_vec = 1'b0;
  logic [2:0]   int_vec_mux = 3'd0;
  logic         int_gate_vec = 1'b0;
  logic         tb_drv = 1'b1;
  wire  [15:0]  bus;

  // Bench holds the bus at zero whenever the DUT must be released; a stray DUT drive disturbs it.
  assign bus = tb_drv ? 16'h0000 : 16'hzzzz;

  always #5 clk = ~clk;

  lc3_int_ctrl #(
    .N_SRC        (N),
    .SRC_PRI      (P_PRI),
    .SRC_VEC      (P_VEC),
    .EDGE_MASK    (P_EDGE),
    .SPURIOUS_VEC (8'hFF)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .irq_req      (irq_req),
    .irq_ack      (irq_ack),
    .int_pri      (int_pri),
    .int_ld_vec   (int_ld_vec),
    .int_vec_mux  (int_vec_mux),
    .int_gate_vec (int_gate_vec),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;

  // hist[j] = request vector sampled j clock edges ago (hist[0] = this edge).
  logic [N-1:0] hist [0:3];
  logic [N-1:0] m_pend, m_act, m_ack;
  logic [2:0]   m_pri;
  logic [7:0]   m_vec;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 4; j++) hist[j] = '0;
    m_pend = '0; m_act = '0; m_ack = '0; m_pri = '0; m_vec = 8'h00;
  endtask

  task automatic model_edge();
    int           w;
    logic [2:0]   wp;
    logic [N-1:0] clr, lvl, rise;
    w = -1; wp = 3'd0; clr = '0;
    for (int i = 0; i < N; i++)
      if (m_act[i] && P_PRI[3*i +: 3] > wp) begin
        wp = P_PRI[3*i +: 3];
        w  = i;
      end
    if (int_ld_vec) begin
      case (int_vec_mux[1:0])
        2'd0: if (w >= 0) begin m_vec = P_VEC[8*w +: 8]; clr[w] = 1'b1; end
              else m_vec = 8'hFF;
        2'd1: m_vec = 8'h00;
        2'd2: m_vec = 8'h01;
        default: m_vec = 8'h02;
      endcase
    end
    hist[0] = irq_req;
    lvl  = hist[D];
    rise = hist[D] & ~hist[D+1];
    m_pend = rise | (m_pend & ~clr);
    m_act  = (P_EDGE & m_pend) | (~P_EDGE & lvl);
    m_pri  = wp;
    m_ack  = clr;
    for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
  endtask

  // Called at a falling edge: drive, check bus, take one rising edge, check registers.
  task automatic step(input logic [N-1:0] req, input logic ld, input logic [2:0] mux,
                      input logic gate);
    irq_req = req; int_ld_vec = ld; int_vec_mux = mux; int_gate_vec = gate; tb_drv = !gate;
    #1 chk("bus", bus, gate ? {8'h01, m_vec} : 16'h0000);
    @(posedge clk);
    model_edge();
    #1;
    chk("int_pri", {13'd0, int_pri}, {13'd0, m_pri});
    chk("irq_ack", {12'd0, irq_ack}, {12'd0, m_ack});
    @(negedge clk);
  endtask

  task automatic idle(input logic [N-1:0] req, input int n);
    for (int k = 0; k < n; k++) step(req, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic peek_gate(input string tag, input logic [15:0] exp);
    int_ld_vec = 1'b0; int_gate_vec = 1'b1; tb_drv = 1'b0;
    #1 chk(tag, bus, exp);
    int_gate_vec = 1'b0; tb_drv = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    chk("rst_pri", {13'd0, int_pri}, 16'd0);
    chk("rst_ack", {12'd0, irq_ack}, 16'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Level source 1 (pri 4, vec 81).
    idle(4'b0010, D + 2);
    chk("lvl_pri", {13'd0, int_pri}, 16'd4);
    step(4'b0010, 1'b1, 3'd0, 1'b0);
    chk("lvl_ack", {12'd0, irq_ack}, 16'h0002);
    idle(4'b0000, D + 2);
    chk("lvl_drop_pri", {13'd0, int_pri}, 16'd0);
    peek_gate("lvl_vec", 16'h0181);

    // Edge source 2 (pri 5) over level source 1 (pri 4).
    step(4'b0110, 1'b0, 3'd0, 1'b0);
    idle(4'b0010, D + 1);
    chk("hi_pri", {13'd0, int_pri}, 16'd5);
    step(4'b0010, 1'b1, 3'd0, 1'b0);
    chk("hi_ack", {12'd0, irq_ack}, 16'h0004);
    idle(4'b0010, 1);
    chk("post_ack_pri", {13'd0, int_pri}, 16'd4);
    peek_gate("hi_vec", 16'h0182);

    // Tie at priority 4: source 0 beats source 1.
    step(4'b0011, 1'b0, 3'd0, 1'b0);
    idle(4'b0010, D + 1);
    step(4'b0010, 1'b1, 3'd0, 1'b0);
    chk("tie_ack", {12'd0, irq_ack}, 16'h0001);
    peek_gate("tie_vec", 16'h0180);

    // Exception vectors with source 1 still active; bit 2 of the mux is ignored.
    step(4'b0010, 1'b1, 3'd1, 1'b0);
    chk("priv_ack", {12'd0, irq_ack}, 16'h0000);
    chk("priv_pri", {13'd0, int_pri}, 16'd4);
    peek_gate("priv_vec", 16'h0100);
    step(4'b0010, 1'b1, 3'd6, 1'b0);
    peek_gate("ill_vec", 16'h0101);
    step(4'b0010, 1'b1, 3'd3, 1'b1);
    peek_gate("acv_vec", 16'h0102);

    // Only the priority-0 source active: spurious vector, no ack.
    idle(4'b1000, D + 2);
    chk("pri0_pri", {13'd0, int_pri}, 16'd0);
    step(4'b1000, 1'b1, 3'd0, 1'b0);
    chk("spur_ack", {12'd0, irq_ack}, 16'h0000);
    peek_gate("spur_vec", 16'h01FF);

    // Edge source 0: pulse held, then a second pulse lands on the ack edge.
    step(4'b0001, 1'b0, 3'd0, 1'b0);
    idle(4'b0000, D + 1);
    chk("edge_hold_pri", {13'd0, int_pri}, 16'd4);
    step(4'b0001, 1'b0, 3'd0, 1'b0);
    idle(4'b0000, D - 1);
    step(4'b0000, 1'b1, 3'd0, 1'b0);
    chk("edge_rearm_ack", {12'd0, irq_ack}, 16'h0001);
    idle(4'b0000, 2);
    chk("edge_rearm_pri", {13'd0, int_pri}, 16'd4);
    step(4'b0000, 1'b1, 3'd0, 1'b0);
    idle(4'b0000, 2);
    chk("edge_clear_pri", {13'd0, int_pri}, 16'd0);

    // Asynchronous reset in the middle of a cycle with a source active and the gate high.
    idle(4'b0010, D + 2);
    step(4'b0010, 1'b1, 3'd0, 1'b0);
    int_gate_vec = 1'b1; tb_drv = 1'b1;
    #3 arst_n = 1'b0;
    #1;
    chk("rst_mid_pri", {13'd0, int_pri}, 16'd0);
    chk("rst_mid_ack", {12'd0, irq_ack}, 16'd0);
    chk("rst_mid_bus", bus, 16'h0000);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1; int_gate_vec = 1'b0;
    peek_gate("rst_vec", 16'h0100);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++)
      step(N'($urandom), ($urandom_range(3) == 0), 3'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_int_ctrl.md
# lc3_int_ctrl

Interrupt and exception-vector controller for the LC-3 Patt-microarchitecture CPU.
- Collects device interrupt requests, arbitrates them by fixed per-source priority and presents the winning priority on `int_pri`.
- On the CPU's `int_ld_vec` strobe, latches the interrupt or exception vector and acknowledges the serviced source.
- Drives the trap/interrupt table address onto the shared system bus when `int_gate_vec` is asserted.

## Interface
Parameters:
- `N_SRC`, 2: number of device interrupt sources (1–8).
- `SRC_PRI`, {3'd5, 3'd4}: packed 3·N_SRC; priority of source i at [3i+2:3i]. Priority 0 never interrupts.
- `SRC_VEC`, {8'h81, 8'h80}: packed 8·N_SRC; 8-bit vector of source i.
- `EDGE_MASK`, 2'b00: bit i = 1 makes source i edge-triggered (rising edge latched); 0 makes it level-sensitive.
- `SPURIOUS_VEC`, 8'hFF: vector loaded when an interrupt vector load finds no active source.

Ports:
- `clk` in 1: clock.
- `arst_n` in 1: reset, asynchronous, active-low.
- `irq_req` in N_SRC: device requests, already qualified by device IE bits; asynchronous to clk.
- `irq_ack` out N_SRC: one-cycle acknowledge to the serviced source.
- `int_pri` out 3: registered priority of the current winner; 0 when none is active.
- `int_ld_vec` in 1: load vector register (LD.Vector).
- `int_vec_mux` in 3: vector select; bits [1:0] used, bit 2 ignored.
- `int_gate_vec` in 1: gate vector onto the bus (GateVector).
- `bus` inout 16: system bus.

## Operation
- Each source passes through a synchronizer into an `active[i]` register:
  - Level source: `active` = synced level.
  - Edge source: `active` = pending flag, set on synced rising edge, cleared by ack.
- Arbitration is combinational over `active`, then registered:
  - Winner = highest SRC_PRI among active sources with nonzero priority.
  - Ties go to the lowest index.
  - `int_pri` ← winner's priority, or 0 if there is no winner.
- Vector register, on `int_ld_vec` (according to `int_vec_mux[1:0]`):
  - 0: vec ← SRC_VEC[winner], and `irq_ack[winner]` pulses. With no winner: vec ← SPURIOUS_VEC and no ack.
  - 1: vec ← 8'h00 (privilege violation). No ack.
  - 2: vec ← 8'h01 (illegal opcode). No ack.
  - 3: vec ← 8'h02 (ACV). No ack.
- Bus drive:
  - `int_gate_vec` = 1: bus = {8'h01, vec}.
  - Otherwise: bus = 16'bz.
  - The block never drives the bus in any other cycle.
- Edge pending:
  - Cleared at the same edge that loads its vector.
  - A new synced rising edge at that same edge wins: pending stays set and the event is not lost.
- Level sources:
  - The device must drop its request after seeing `irq_ack`.
  - Until it does, the source stays active and the block takes no action.

## Timing
- Reset values (async, immediate, also mid-operation):
  - `int_pri` = 0, `irq_ack` = 0, vec = 8'h00, all pending, synchronizer and active flops = 0, bus released.
- Request latency (request first sampled high at edge 0):
  - With INT_CTRL_SYNC_EN: `active` set at edge 2, `int_pri` valid after edge 3.
  - Without: `active` set at edge 1, `int_pri` valid after edge 2.
  - Same latency for level and edge sources.
- Ack: `irq_ack` is high for exactly the cycle following the `int_ld_vec` edge.
- Post-ack:
  - `int_pri` reflects the cleared pending flag one edge after the ack edge.
  - A level source keeps its priority until its synced level falls.
- Edge-source minimum pulse width: one clk period, and it must be captured by the first synchronizer flop.
- Vector stability: vec holds its value between loads, so a gated read always returns the last loaded vector.
- `int_ld_vec` and `int_gate_vec` in the same cycle: the bus shows the old vec; the new vec is visible from the next cycle.

## Configuration
- `INT_CTRL_SYNC_EN` defined: 2-flop synchronizer per source before edge detect and active logic.
- `INT_CTRL_SYNC_EN` undefined: single input register per source, for synchronous devices and simulation.
  - Latency is one cycle shorter.
  - Function is otherwise identical.

## Structure
- Package `lc3_int_pkg`:
  - Vector-mux encodings VEC_INT/VEC_PRIV/VEC_ILL/VEC_ACV.
  - Exception vectors 8'h00/8'h01/8'h02.
  - TABLE_BASE = 8'h01.
  - PRI_W = 3, VEC_W = 8.
- Sub-module `lc3_int_src`:
  - One per source (generate loop).
  - Contains the synchronizer (macro-controlled), edge detect, pending flag with set-priority clear, and level/edge selection.
  - Outputs `active`.

## Test plan
- Reset: assert `arst_n` low mid-cycle with src0 active → `int_pri`=0, `irq_ack`=0, bus high-Z immediately.
- Level src0 (pri 4) high → `int_pri`=4 after 3 edges (SYNC_EN). Then `int_ld_vec`, mux 0 → `irq_ack`=2'b01 for one cycle. Then gate → bus=16'h0180.
- src0 (pri 4) and src1 (pri 5) both high → `int_pri`=5. Vector load → vec 8'h81, `irq_ack`=2'b10. Drop src1 → `int_pri` returns to 4.
- Equal priorities (override SRC_PRI to 4,4), both high → winner src0, bus=16'h0180 after gate.
- `int_vec_mux`=1 with src0 active → gate gives 16'h0100, no ack, `int_pri` still 4. `int_vec_mux`=0 with nothing active → bus 16'h01FF, no ack.
- Edge src0 (EDGE_MASK=01):
  - One-cycle pulse → `int_pri`=4 held after the pulse ends.
  - Second pulse landing on the ack edge → pending remains set, `int_pri` stays 4.
